// File: rtl/cpu_mem_bridge.sv
// Bridge from the CPU MEM stage's held load/store requests to the memory
// controller handshake, with pipeline stall, completion pulse and access timeout.
module cpu_mem_bridge #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter int                TIMEOUT  = 64,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_rd,
   input  logic              i_req_wr,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wr_data,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_stall,
   output logic              o_done,
   output logic              o_bus_err,
   output logic              o_proto_err,
   output logic [1:0]        o_mc_rw,
   output logic [ADDR_W-1:0] o_mc_addr,
   inout  wire  [DATA_W-1:0] io_mc_data,
   input  logic              i_mc_vld
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              r_is_wr;
   logic              r_err;
   logic              r_proto_err;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic [DATA_W-1:0] r_rd_data;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_req;
   logic              w_timeout;
   logic              w_drive;

   assign w_req     = i_req_rd | i_req_wr;
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

   // The bus is only ours while a write is outstanding in BUSY.
   assign io_mc_data  = w_drive ? r_wr_data : {DATA_W{1'bz}};
   assign o_rd_data   = r_rd_data;
   assign o_mc_addr   = r_addr;
   assign o_proto_err = r_proto_err;

   always_comb begin
      w_state_next = r_state;
      o_stall      = 1'b0;
      o_done       = 1'b0;
      o_bus_err    = 1'b0;
      o_mc_rw      = 2'b00;
      w_drive      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               o_stall      = 1'b1;
               w_state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            o_stall = 1'b1;
            o_mc_rw = {1'b1, ~r_is_wr};
            w_drive = r_is_wr;
            if (i_mc_vld || w_timeout) begin
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            o_done       = 1'b1;
            o_bus_err    = r_err;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_is_wr     <= 1'b0;
         r_err       <= 1'b0;
         r_proto_err <= 1'b0;
         r_addr      <= '0;
         r_wr_data   <= '0;
         r_rd_data   <= '0;
         r_cnt       <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  // A simultaneous rd+wr is treated as a write and flagged.
                  r_addr    <= i_req_addr;
                  r_wr_data <= i_req_wr_data;
                  r_is_wr   <= i_req_wr;
                  r_cnt     <= '0;
                  r_err     <= 1'b0;
                  if (i_req_rd && i_req_wr) begin
                     r_proto_err <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               r_cnt <= r_cnt + 1'b1;
               if (i_mc_vld) begin
                  if (!r_is_wr) begin
                     r_rd_data <= io_mc_data;
                  end
               end else if (w_timeout) begin
                  r_err <= 1'b1;
                  if (!r_is_wr) begin
                     r_rd_data <= ERR_DATA;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
